ps2_rx_scheduler: RTL

Sits between the PS/2 frame decoder and the 68k-side register interface and sequences the receive path. Folds `E0`/`F0` prefix bytes into single key events and buffers the events in a small FIFO. Throttles the keyboard by inhibiting the PS/2 clock line when the buffer nears full. It is the only consumer of the decoder's byte strobe and the only producer of the clock-inhibit request.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_evt_fifo.sv | 63 ++++++
 rtl/ps2_rx_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receive scheduler
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    PFX_IDLE    = 2'd0,
    PFX_EXT     = 2'd1,
    PFX_BRK     = 2'd2,
    PFX_EXT_BRK = 2'd3
  } pfx_state_e;

  typedef enum logic {
    INH_RUN  = 1'b0,
    INH_HOLD = 1'b1
  } inh_state_e;

  function automatic ps2_evt_t make_evt(input pfx_state_e st, input logic [7:0] code);
    ps2_evt_t e;
    e.ext  = (st == PFX_EXT) || (st == PFX_EXT_BRK);
    e.brk  = (st == PFX_BRK) || (st == PFX_EXT_BRK);
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - first-word-fall-through event FIFO, head taken from storage registers
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  ps2_evt_t      wdata_i,
  input  logic          pop_i,
  output ps2_evt_t      head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  ps2_evt_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // When full, a simultaneous pop frees the slot the write lands in.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ps2_rx_scheduler.sv
// rtl/ps2_rx_scheduler.sv - folds E0/F0 prefixes into key events, buffers them, throttles the keyboard clock
module ps2_rx_scheduler
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int INHIBIT_MIN = 1200,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int HW = $clog2(INHIBIT_MIN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  input  logic          rx_err,
  output logic [7:0]    evt_code,
  output logic          evt_ext,
  output logic          evt_break,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] evt_count,
  output logic          overflow,
  input  logic          clr_ovf,
  output logic          ps2_clk_inhibit
);

  pfx_state_e    pfx_q, pfx_d;
  inh_state_e    inh_q, inh_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          ovf_q, ovf_d;

  logic          evt_push;
  ps2_evt_t      evt_data;
  ps2_evt_t      head;
  logic          fifo_full, fifo_empty;
  logic          pop;
  logic [CW-1:0] count;

  always_comb begin
    pfx_d    = pfx_q;
    evt_push = 1'b0;
    evt_data = make_evt(pfx_q, rx_byte);
    if (rx_err) begin
      pfx_d = PFX_IDLE;
    end else if (rx_valid) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        case (pfx_q)
          PFX_IDLE: pfx_d = PFX_EXT;
          PFX_BRK:  pfx_d = PFX_EXT_BRK;
          default:  pfx_d = pfx_q;
        endcase
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        case (pfx_q)
          PFX_IDLE: pfx_d = PFX_BRK;
          PFX_EXT:  pfx_d = PFX_EXT_BRK;
          default:  pfx_d = pfx_q;
        endcase
      end else begin
        evt_push = 1'b1;
        pfx_d    = PFX_IDLE;
      end
    end
  end

  assign pop = !fifo_empty && evt_ready;

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (evt_push),
    .wdata_i (evt_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A set in the same cycle as a clear must survive.
  always_comb begin
    ovf_d = ovf_q;
    if (evt_push && fifo_full && !pop) ovf_d = 1'b1;
    else if (clr_ovf)                  ovf_d = 1'b0;
  end

  // Threshold DEPTH-1 leaves room for a byte the keyboard already has in flight.
  always_comb begin
    inh_d  = inh_q;
    hold_d = hold_q;
    case (inh_q)
      INH_RUN: begin
        if (count >= CW'(DEPTH - 1)) begin
          inh_d  = INH_HOLD;
          hold_d = '0;
        end
      end
      INH_HOLD: begin
        if (hold_q == HW'(INHIBIT_MIN)) begin
          if (count <= CW'(DEPTH / 2)) inh_d = INH_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: inh_d = INH_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pfx_q  <= PFX_IDLE;
      inh_q  <= INH_RUN;
      hold_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pfx_q  <= pfx_d;
      inh_q  <= inh_d;
      hold_q <= hold_d;
      ovf_q  <= ovf_d;
    end
  end

  assign evt_code        = head.code;
  assign evt_ext         = head.ext;
  assign evt_break       = head.brk;
  assign evt_valid       = !fifo_empty;
  assign evt_count       = count;
  assign overflow        = ovf_q;
  assign ps2_clk_inhibit = (inh_q == INH_HOLD);

endmodule
